// File: rtl/div_sched_pkg.sv
`default_nettype none
// =====================================================================
// div_sched_pkg: shared types for the divider scheduler. Rev 1.0
// =====================================================================
package div_sched_pkg;

    localparam int DATA_W    = 64;
    // Widest tag the operand register can carry; the top narrows it to TAG_W.
    localparam int TAG_W_MAX = 16;

    typedef struct packed {
        logic                 signed_div;
        logic [DATA_W-1:0]    dividend;
        logic [DATA_W-1:0]    divisor;
        logic [TAG_W_MAX-1:0] tag;
    } div_req_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        BUSY  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
`ifdef DIV_SCHED_ZERO_EN
        ,
        ZRESP = 3'd5
`endif
    } state_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_sched_rr_arbiter.sv
`default_nettype none
// =====================================================================
// rr_arbiter: one-hot round-robin grant, search starts after last winner.
// Rev 1.0
// =====================================================================
module rr_arbiter
    import div_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] nxt;
    logic             found;

    always_comb begin
        grant   = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win_idx    = idx;
            end
        end
    end

    assign nxt = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_sched.sv
`default_nettype none
// =====================================================================
// div_sched: shares one iterative divider among NUM_REQ requesters.
// Define DIV_SCHED_ZERO_EN to answer divide-by-zero locally. Rev 1.0
// =====================================================================
module div_sched
    import div_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     flush,
    input  logic [NUM_REQ-1:0]                       req_valid,
    output logic [NUM_REQ-1:0]                       req_ready,
    input  logic [NUM_REQ*(1+2*DATA_W+TAG_W)-1:0]    req_op,
    output logic                                     div_valid_in,
    output logic                                     div_yumi,
    output logic                                     div_signed,
    output logic [DATA_W-1:0]                        div_dividend,
    output logic [DATA_W-1:0]                        div_divisor,
    input  logic                                     div_ready,
    input  logic                                     div_valid_out,
    input  logic [DATA_W-1:0]                        div_quotient,
    output logic                                     res_valid,
    output logic [TAG_W-1:0]                         res_tag,
    output logic [DATA_W-1:0]                        res_quotient,
    input  logic                                     res_ready
);

    // Per-requester slice layout: {signed_div, dividend, divisor, tag}, tag at LSB.
    localparam int OP_W = 1 + 2*DATA_W + TAG_W;

    state_t               state;
    div_req_t             op_q;
    div_req_t             sel_op;
    logic [OP_W-1:0]      sel_raw;
    logic [NUM_REQ-1:0]   grant;
    logic                 take;
    logic                 zresp;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (take),
        .grant   (grant)
    );

    always_comb begin
        sel_raw = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_raw = req_op[i*OP_W +: OP_W];
            end
        end
    end

    always_comb begin
        sel_op            = '0;
        sel_op.signed_div = sel_raw[OP_W-1];
        sel_op.dividend   = sel_raw[OP_W-2 -: DATA_W];
        sel_op.divisor    = sel_raw[TAG_W +: DATA_W];
        sel_op.tag        = TAG_W_MAX'(sel_raw[TAG_W-1:0]);
    end

    assign take = (state == IDLE) && !flush && (|grant);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            op_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) begin
                        op_q <= sel_op;
`ifdef DIV_SCHED_ZERO_EN
                        state <= (sel_op.divisor == '0) ? ZRESP : ISSUE;
`else
                        state <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (div_ready) begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // A killed op must still be retired from the divider.
                    if (flush) begin
                        state <= DRAIN;
                    end else if (div_valid_out) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (flush || res_ready) begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (div_valid_out) begin
                        state <= IDLE;
                    end
                end
`ifdef DIV_SCHED_ZERO_EN
                ZRESP: begin
                    if (flush || res_ready) begin
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DIV_SCHED_ZERO_EN
    assign zresp = (state == ZRESP);
`else
    assign zresp = 1'b0;
`endif

    assign req_ready    = (state == IDLE && !flush) ? grant : '0;
    assign div_valid_in = (state == ISSUE) && div_ready && !flush;
    assign div_yumi     = ((state == RESP) && (flush || res_ready)) ||
                          ((state == DRAIN) && div_valid_out);
    assign div_signed   = op_q.signed_div;
    assign div_dividend = op_q.dividend;
    assign div_divisor  = op_q.divisor;

    assign res_valid    = ((state == RESP) || zresp) && !flush;
    assign res_tag      = TAG_W'(op_q.tag);
    assign res_quotient = zresp ? '1 : div_quotient;

endmodule
`default_nettype wire

// File: tb/tb_div_sched.sv
`default_nettype none
// =====================================================================
// tb_div_sched: directed bench for div_sched with a behavioural divider.
// Rev 1.0
// =====================================================================
module tb_div_sched;

    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 6;
    localparam int DW      = 64;
    localparam int OP_W    = 1 + 2*DW + TAG_W;
    localparam logic [DW-1:0] DIV0_PATTERN = 64'hDEAD_BEEF_0BAD_F00D;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      flush = 1'b0;
    logic                      res_ready = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*OP_W-1:0]   req_op = '0;
    logic                      div_valid_in, div_yumi, div_signed;
    logic [DW-1:0]             div_dividend, div_divisor;
    logic                      div_ready, div_valid_out;
    logic [DW-1:0]             div_quotient;
    logic                      res_valid;
    logic [TAG_W-1:0]          res_tag;
    logic [DW-1:0]             res_quotient;

    div_sched #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .div_valid_in  (div_valid_in),
        .div_yumi      (div_yumi),
        .div_signed    (div_signed),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_ready     (div_ready),
        .div_valid_out (div_valid_out),
        .div_quotient  (div_quotient),
        .res_valid     (res_valid),
        .res_tag       (res_tag),
        .res_quotient  (res_quotient),
        .res_ready     (res_ready)
    );

    always #5 clk = ~clk;

    // Divider: accepts when idle, result valid `lat` cycles later, held until yumi.
    int            lat = 4;
    logic          dbusy = 1'b0;
    int            dcnt = 0;
    logic [DW-1:0] dq = '0;

    function automatic logic [DW-1:0] model_div(input logic s, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        if (b == '0) return DIV0_PATTERN;
        if (s) return $signed(a) / $signed(b);
        return a / b;
    endfunction

    assign div_ready     = !dbusy;
    assign div_valid_out = dbusy && (dcnt == 0);
    assign div_quotient  = dq;

    always @(posedge clk) begin
        if (reset) begin
            dbusy <= 1'b0;
            dcnt  <= 0;
            dq    <= '0;
        end else if (div_valid_in && div_ready) begin
            dbusy <= 1'b1;
            dcnt  <= lat - 1;
            dq    <= model_div(div_signed, div_dividend, div_divisor);
        end else if (dbusy) begin
            if (dcnt > 0) dcnt <= dcnt - 1;
            else if (div_yumi) dbusy <= 1'b0;
        end
    end

    int               cyc = 0, vin_cnt = 0, yumi_cnt = 0, rv_cnt = 0, yumi_bad = 0;
    int               gq[$];
    int               gcyc[$];
    logic [TAG_W-1:0] tq[$];
    logic [DW-1:0]    qq[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    gq.push_back(i);
                    gcyc.push_back(cyc);
                end
            end
            if (res_valid && res_ready) begin
                tq.push_back(res_tag);
                qq.push_back(res_quotient);
            end
            if (res_valid)                  rv_cnt   <= rv_cnt + 1;
            if (div_yumi)                   yumi_cnt <= yumi_cnt + 1;
            if (div_valid_in)               vin_cnt  <= vin_cnt + 1;
            if (div_yumi && !div_valid_out) yumi_bad <= yumi_bad + 1;
        end
    end

    int n_pass = 0, n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_op(input int i, input logic s, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [TAG_W-1:0] t);
        req_op[i*OP_W +: OP_W] = {s, a, b, t};
    endtask

    task automatic wait_res(inout int n);
        while (!res_valid && n < 80) begin
            step();
            n++;
        end
        chk("res_timeout", res_valid, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n, g0, t0, r0, y0, v0;
        logic ok;
        int   exp_g[5];
        int   exp_t[5];
        int   exp_q[5];

        // Reset
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_div_valid_in", div_valid_in, 0);
        chk("rst_div_yumi", div_yumi, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_dividend", div_dividend, 0);
        chk("rst_divisor", div_divisor, 0);

        // Single op 100/7 tag 5
        set_op(0, 1'b0, 100, 7, 5);
        req_valid = 4'b0001;
        #1;
        chk("single_grant", req_ready, 4'b0001);
        n = 0;
        step(); n++;
        req_valid = '0;
        #1;
        chk("single_vin", div_valid_in, 1);
        chk("single_dividend", div_dividend, 100);
        chk("single_divisor", div_divisor, 7);
        wait_res(n);
        chk("single_latency", n, 6);
        chk("single_tag", res_tag, 5);
        chk("single_quot", res_quotient, 14);
        chk("single_yumi", div_yumi, 1);
        chk("single_opnd_stable", div_dividend, 100);
        y0 = yumi_cnt;
        step();
        step();
        chk("single_yumi_once", yumi_cnt - y0, 1);
        chk("single_vin_once", vin_cnt, 1);
        chk("single_res_done", res_valid, 0);

        // Fairness after fresh reset
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        gq.delete(); gcyc.delete(); tq.delete(); qq.delete();
        set_op(0, 1'b0, 20, 4, 10);
        set_op(1, 1'b0, 21, 3, 11);
        set_op(2, 1'b0, 100, 10, 12);
        set_op(3, 1'b0, 81, 9, 13);
        req_valid = 4'hF;
        n = 0;
        while (!(res_valid && res_ready && tq.size() == 4) && n < 200) begin
            step();
            n++;
        end
        req_valid = '0;
        step(); step();
        exp_g = '{0, 1, 2, 3, 0};
        exp_t = '{10, 11, 12, 13, 10};
        exp_q = '{5, 7, 10, 9, 5};
        chk("fair_grants", gq.size(), 5);
        chk("fair_results", tq.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fair_grant%0d", i), gq[i], exp_g[i]);
            chk($sformatf("fair_tag%0d", i), tq[i], exp_t[i]);
            chk($sformatf("fair_quot%0d", i), qq[i], exp_q[i]);
        end
        chk("fair_b2b_gap", gcyc[1] - gcyc[0], 7);

        // Backpressure on result
        res_ready = 1'b0;
        set_op(2, 1'b0, 50, 5, 7);
        req_valid = 4'b0100;
        #1;
        chk("bp_grant", req_ready, 4'b0100);
        n = 0;
        step(); n++;
        req_valid = 4'b0110;
        wait_res(n);
        g0 = gq.size();
        ok = 1'b1;
        repeat (10) begin
            step();
            if (!(res_valid === 1'b1 && res_tag === 6'd7 && res_quotient === 64'd10 &&
                  div_yumi === 1'b0 && req_ready === 4'b0000)) ok = 1'b0;
        end
        chk("bp_hold", ok, 1);
        chk("bp_nogrant", gq.size(), g0);
        req_valid = '0;
        res_ready = 1'b1;
        #1;
        chk("bp_yumi", div_yumi, 1);
        chk("bp_valid", res_valid, 1);
        step();
        chk("bp_accept_cnt", tq.size(), 6);
        chk("bp_accept_tag", tq[5], 7);

        // Flush while BUSY
        lat = 10;
        set_op(3, 1'b0, 64'h4000_0000_0000_0000, 3, 9);
        req_valid = 4'b1000;
        #1;
        chk("fb_grant", req_ready, 4'b1000);
        r0 = rv_cnt; y0 = yumi_cnt; v0 = vin_cnt;
        step();
        req_valid = '0;
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (20) step();
        chk("fb_no_res", rv_cnt - r0, 0);
        chk("fb_yumi_once", yumi_cnt - y0, 1);
        chk("fb_vin_once", vin_cnt - v0, 1);
        chk("fb_yumi_on_vout", yumi_bad, 0);
        lat = 4;
        set_op(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 2, 3);
        req_valid = 4'b0001;
        #1;
        chk("fb_next_grant", req_ready, 4'b0001);
        n = 0;
        step(); n++;
        req_valid = '0;
        wait_res(n);
        chk("fb_signed_quot", res_quotient, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("fb_signed_tag", res_tag, 3);
        step();

        // Flush coincident with res_ready in RESP, then flush in IDLE
        res_ready = 1'b0;
        set_op(1, 1'b0, 30, 3, 4);
        req_valid = 4'b0010;
        #1;
        chk("fr_grant", req_ready, 4'b0010);
        n = 0;
        step(); n++;
        req_valid = '0;
        wait_res(n);
        t0 = tq.size();
        flush = 1'b1;
        res_ready = 1'b1;
        #1;
        chk("fr_res_valid", res_valid, 0);
        chk("fr_yumi", div_yumi, 1);
        step();
        req_valid = 4'hF;
        #1;
        chk("fi_no_ready", req_ready, 0);
        g0 = gq.size();
        step();
        flush = 1'b0;
        #1;
        chk("fi_ptr_kept", req_ready, 4'b0100);
        chk("fr_no_accept", tq.size(), t0);
        chk("fi_no_grant", gq.size(), g0);
        step();
        req_valid = '0;
        n = 1;
        wait_res(n);
        chk("fi_quot", res_quotient, 10);
        chk("fi_tag", res_tag, 7);
        step();

        // Flush while ISSUE
        set_op(0, 1'b0, 9, 0, 2);
        req_valid = 4'b1000;
        #1;
        chk("fiss_grant", req_ready, 4'b1000);
        step();
        req_valid = '0;
        flush = 1'b1;
        #1;
        chk("fiss_vin", div_valid_in, 0);
        v0 = vin_cnt;
        step();
        flush = 1'b0;
        req_valid = 4'b0001;
        #1;
        chk("fiss_idle", req_ready, 4'b0001);
        chk("fiss_vin_cnt", vin_cnt, v0);

        // Divide by zero 9/0 tag 2
        n = 0;
        step(); n++;
        req_valid = '0;
`ifdef DIV_SCHED_ZERO_EN
        chk("z_valid", res_valid, 1);
        chk("z_quot", res_quotient, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("z_tag", res_tag, 2);
        chk("z_vin", div_valid_in, 0);
        chk("z_yumi", div_yumi, 0);
        step();
        chk("z_vin_cnt", vin_cnt, v0);
        chk("z_done", res_valid, 0);
`else
        wait_res(n);
        chk("z_latency", n, 6);
        chk("z_quot_fwd", res_quotient, DIV0_PATTERN);
        chk("z_tag", res_tag, 2);
        step();
        chk("z_vin_cnt", vin_cnt, v0 + 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
